ahb_rom_arbiter: RTL and testbench
==================================

Name: ahb_rom_arbiter

Overview:
- Shares one synchronous single-port code ROM between two AHB-Lite slave ports: port 0 (I-code fetch) and port 1 (D-code literal/data reads).
- Resolves same-cycle read conflicts by stalling the loser for exactly one wait state via HREADYOUT, then serving its captured address.
- Sits between the Cortex-M3 I-code/D-code bus matrix outputs and the ROM macro (address in, registered q out, 1-cycle read latency).

Parameters:
- ADDR_W, 13, ROM word-address width; rom_addr = HADDRx[ADDR_W+1:2].
- PRIO, 1, port that wins when both ports present new requests in the same cycle (0 or 1).

Ports:
- HCLK  input  1  bus clock; the only clock.
- HRESETn  input  1  synchronous, active-low reset.
- HSEL0 / HSEL1  input  1  slave select, port 0 / port 1.
- HREADY0 / HREADY1  input  1  bus-level HREADY seen by each port.
- HADDR0 / HADDR1  input  32  address-phase address.
- HTRANS0 / HTRANS1  input  2  transfer type.
- HWRITE0 / HWRITE1  input  1  write flag.
- HSIZE0 / HSIZE1  input  3  size; ignored (word reads only).
- HWDATA0 / HWDATA1  input  32  ignored.
- HREADYOUT0 / HREADYOUT1  output  1  per-port slave ready.
- HRDATA0 / HRDATA1  output  32  per-port read data.
- rom_addr  output  ADDR_W  ROM word address (combinational from grant mux).
- rom_en  output  1  high in a cycle where a ROM read is issued.
- rom_q  input  32  ROM registered output, valid one cycle after rom_addr is sampled.

Behaviour:
- New request on port p in cycle t: HSELp & HREADYp & HTRANSp[1] & ~HWRITEp.
- Per-port state, registered: pend_p (stalled request held), pend_addr_p, dvalid_p (ROM read issued for p last cycle).
- Candidate for port p: pend_p or new_req_p. These are mutually exclusive because a stalled port holds HREADYp low.
- Grant rules, evaluated combinationally each cycle:
  - One candidate: it wins.
  - Both candidates, one pending: the pending port wins. This bounds the stall to one cycle and prevents starvation.
  - Both new: port PRIO wins.
- Winner: rom_en = 1. rom_addr = pend_addr_p if pending, else HADDRp[ADDR_W+1:2]. Set dvalid_p at the next edge.
- Loser, which is always new: capture pend_p = 1 and pend_addr_p at the next edge.
- No candidate: rom_en = 0, rom_addr = 0.
- HREADYOUTp = ~pend_p. HRDATAp = rom_q when dvalid_p, else 32'h0.
- pend_p clears at the edge where it is granted. dvalid_p is set for exactly one cycle per granted read.
- Latency:
  - Uncontended read: zero wait states, data in the cycle after the address phase.
  - Contended loser: exactly one wait state.
- Writes (HWRITEp=1 with a valid transfer): no ROM access, zero-wait OKAY, HRDATAp = 0. A write never competes for the grant.
- IDLE/BUSY transfers, or HREADYp = 0: not a request; no state change for that port.
- A pending request is served regardless of later changes in HSELp or HADDRp.
- Reset (HRESETn = 0 at an edge): pend_p = 0, dvalid_p = 0.
  - Consequences: HREADYOUTp = 1, HRDATAp = 0, rom_en = 0.
  - A mid-stall reset drops the pending request.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - Port index constants: PORT_I=0, PORT_D=1.
- One sub-module, ahb_rom_port, instantiated twice:
  - Contains request decode, pend/pend_addr/dvalid registers, and HREADYOUT/HRDATA generation.
  - Inputs: grant, is_winner.
  - Outputs: cand, cand_is_pend, cand_addr.
- The top level holds only the grant mux and the ROM-side signals.

Test Plan:
- Port 0 NONSEQ read at 0x0000_0010, port 1 idle:
  - rom_en = 1 and rom_addr = 4 in the address cycle.
  - Next cycle: HREADYOUT0 = 1, HRDATA0 = mem[4].
- Both ports NONSEQ read in the same cycle, port 0 at 0x20 and port 1 at 0x40, PRIO = 1:
  - t: rom_addr = 16.
  - t+1: HRDATA1 = mem[16], HREADYOUT0 = 0, rom_addr = 8.
  - t+2: HREADYOUT0 = 1, HRDATA0 = mem[8].
- Back-to-back contention, with port 1 issuing a new read at t+1 while port 0 is pending:
  - Port 0 pending wins.
  - Port 1 stalls one cycle; its data returns at t+3.
  - No port ever sees two consecutive wait states.
- Port 1 write to 0x100 concurrent with a port 0 read:
  - Port 0 gets zero wait states.
  - Port 1 sees HREADYOUT1 = 1 and HRDATA1 = 0.
  - rom_addr carries port 0's address only.
- HTRANS = BUSY, or HREADY0 = 0 with HSEL0 = 1: rom_en = 0 and no state change.
- Assert HRESETn = 0 for one edge while port 0 is pending: the next cycle has HREADYOUT0 = 1, rom_en = 0, HRDATA0 = 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and port indices for the dual-port code ROM arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    // Only NONSEQ and SEQ carry an address phase that must be served.
    function automatic logic is_xfer(input logic [1:0] htrans);
        return htrans_e'(htrans) inside {NONSEQ, SEQ};
    endfunction

endpackage

// File: rtl/ahb_rom_arbiter_if.sv
// One AHB-Lite slave port as seen by the ROM arbiter; instantiated once per bus.
interface ahb_rom_arbiter_if;

    logic        hsel;
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;

    modport master (
        output hsel, hready, haddr, htrans, hwrite, hsize, hwdata,
        input  hreadyout, hrdata
    );

    modport slave (
        input  hsel, hready, haddr, htrans, hwrite, hsize, hwdata,
        output hreadyout, hrdata
    );

endinterface

// File: rtl/ahb_rom_port.sv
// Per-port request decode, one-deep stall buffer and read-data return for the shared ROM.
module ahb_rom_port
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    ahb_rom_arbiter_if.slave  bus,
    input  logic [31:0]       rom_q,
    input  logic              grant,
    input  logic              is_winner,
    output logic              cand,
    output logic              cand_is_pend,
    output logic [ADDR_W-1:0] cand_addr
);

    logic              new_req;
    logic              lost;
    logic              pend;
    logic              dvalid;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] pend_addr;
    logic              unused_bits;

    // Writes never reach the ROM; they complete with zero waits and zero data.
    assign new_req  = bus.hsel & bus.hready & is_xfer(bus.htrans) & ~bus.hwrite;
    assign req_addr = bus.haddr[ADDR_W+1:2];
    assign lost     = grant & new_req & ~is_winner;

    assign cand         = pend | new_req;
    assign cand_is_pend = pend;
    assign cand_addr    = pend ? pend_addr : req_addr;

    assign bus.hreadyout = ~pend;
    assign bus.hrdata    = dvalid ? rom_q : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= is_winner;
            if (is_winner) begin
                pend <= 1'b0;
            end else if (lost) begin
                pend <= 1'b1;
            end
        end
    end

    // NOTE: pend_addr is deliberately left out of reset; it is only observed
    // while pend is set, and pend is always written together with it.
    always_ff @(posedge clk) begin
        if (lost) begin
            pend_addr <= req_addr;
        end
    end

    // Size, write data and the byte/upper address bits have no effect on a word ROM.
    assign unused_bits = ^{bus.hsize, bus.hwdata, bus.haddr[31:ADDR_W+2], bus.haddr[1:0]};

    // A stalled request always wins the next cycle, so a wait never repeats.
    a_single_wait: assert property (@(posedge clk) disable iff (!rst_n) pend |=> !pend);

endmodule

// File: rtl/ahb_rom_arbiter.sv
// Shares one synchronous single-port code ROM between the I-code and D-code AHB-Lite
// ports; a same-cycle conflict costs the loser exactly one wait state.
module ahb_rom_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int PRIO   = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_rom_arbiter_if.slave  p0,
    ahb_rom_arbiter_if.slave  p1,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [31:0]       rom_q
);

    logic [1:0]        cand;
    logic [1:0]        cand_is_pend;
    logic [1:0]        winner;
    logic [ADDR_W-1:0] cand_addr [2];

    ahb_rom_port #(.ADDR_W(ADDR_W)) u_port_i (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .bus          (p0),
        .rom_q        (rom_q),
        .grant        (rom_en),
        .is_winner    (winner[PORT_I]),
        .cand         (cand[PORT_I]),
        .cand_is_pend (cand_is_pend[PORT_I]),
        .cand_addr    (cand_addr[PORT_I])
    );

    ahb_rom_port #(.ADDR_W(ADDR_W)) u_port_d (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .bus          (p1),
        .rom_q        (rom_q),
        .grant        (rom_en),
        .is_winner    (winner[PORT_D]),
        .cand         (cand[PORT_D]),
        .cand_is_pend (cand_is_pend[PORT_D]),
        .cand_addr    (cand_addr[PORT_D])
    );

    // A pending port beats a new one, which bounds every stall to a single cycle.
    always_comb begin
        // NOTE: defaulting winner first keeps this block free of inferred latches.
        winner = 2'b00;
        if (cand[PORT_I] && cand[PORT_D]) begin
            if (cand_is_pend[PORT_I]) begin
                winner[PORT_I] = 1'b1;
            end else if (cand_is_pend[PORT_D]) begin
                winner[PORT_D] = 1'b1;
            end else if (PRIO == PORT_D) begin
                winner[PORT_D] = 1'b1;
            end else begin
                winner[PORT_I] = 1'b1;
            end
        end else begin
            winner = cand;
        end
    end

    assign rom_en = |cand;

    always_comb begin
        rom_addr = '0;
        if (winner[PORT_D]) begin
            rom_addr = cand_addr[PORT_D];
        end else if (winner[PORT_I]) begin
            rom_addr = cand_addr[PORT_I];
        end
    end

    a_one_winner: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(winner));

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Self-checking bench: a ROM model plus per-port read-data scoreboards, driven by
// per-scenario cycle tables with hand-derived arbitration expectations.
module tb_ahb_rom_arbiter;
    import ahb_pkg::*;

    localparam int ADDR_W = 13;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
    } stim_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic              rdy0;
        logic              rdy1;
    } obs_t;

    typedef enum logic [1:0] {DP_NONE, DP_READ, DP_WRITE} dp_e;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall0 = 1'b0;
    logic              stall1 = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [31:0]       rom_q;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    dp_e         dp [2] = '{DP_NONE, DP_NONE};
    logic        prev_wait [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    ahb_rom_arbiter_if bus0 ();
    ahb_rom_arbiter_if bus1 ();

    // Single slave on each bus: the bus-level HREADY follows this slave unless forced low.
    assign bus0.hready = bus0.hreadyout & ~stall0;
    assign bus1.hready = bus1.hreadyout & ~stall1;

    ahb_rom_arbiter #(.ADDR_W(ADDR_W), .PRIO(1)) dut (
        .HCLK     (clk),
        .HRESETn  (rst_n),
        .p0       (bus0),
        .p1       (bus1),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_q    (rom_q)
    );

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        return {3'b101, a, 3'b011, ~a};
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_word(rom_addr);
    end

    function automatic stim_t rd(input logic [31:0] a);
        return '{sel: 1'b1, trans: NONSEQ, write: 1'b0, addr: a};
    endfunction

    function automatic stim_t wr(input logic [31:0] a);
        return '{sel: 1'b1, trans: NONSEQ, write: 1'b1, addr: a};
    endfunction

    function automatic stim_t idl();
        return '{sel: 1'b0, trans: IDLE, write: 1'b0, addr: 32'h0};
    endfunction

    function automatic obs_t ob(input logic en, input int a, input logic r0, input logic r1);
        return '{en: en, addr: ADDR_W'(a), rdy0: r0, rdy1: r1};
    endfunction

    // One bus cycle: drive, sample at the falling edge, score read data, then advance.
    task automatic cyc(input stim_t s0, input stim_t s1, input logic rst_low, output obs_t o);
        stim_t       s [2];
        logic        rdy [2];
        logic        hr [2];
        logic [31:0] rdata [2];
        logic [31:0] exp;
        logic        underflow;
        s[0] = s0;
        s[1] = s1;
        rst_n = ~rst_low;
        bus0.hsel = s0.sel; bus0.htrans = s0.trans; bus0.hwrite = s0.write; bus0.haddr = s0.addr;
        bus1.hsel = s1.sel; bus1.htrans = s1.trans; bus1.hwrite = s1.write; bus1.haddr = s1.addr;
        bus0.hsize = 3'b010; bus1.hsize = 3'b010;
        bus0.hwdata = $urandom(); bus1.hwdata = $urandom();
        @(negedge clk);
        o = ob(rom_en, int'(rom_addr), bus0.hreadyout, bus1.hreadyout);
        rdy[0] = bus0.hreadyout;  rdy[1] = bus1.hreadyout;
        hr[0] = bus0.hready;      hr[1] = bus1.hready;
        rdata[0] = bus0.hrdata;   rdata[1] = bus1.hrdata;
        for (int p = 0; p < 2; p++) begin
            exp = 32'h0;
            underflow = 1'b0;
            if (dp[p] == DP_READ && rdy[p] === 1'b1) begin
                if (p == 0 && exp_q0.size() > 0) exp = exp_q0.pop_front();
                else if (p == 1 && exp_q1.size() > 0) exp = exp_q1.pop_front();
                else underflow = 1'b1;
            end
            vectors++;
            if (underflow || rdata[p] !== exp) begin
                miscompares++;
                $display("FAIL hrdata%0d @%0t: got %h, expected %h (underflow=%0b)",
                         p, $time, rdata[p], exp, underflow);
            end
            if (rdy[p] !== 1'b1) begin
                vectors++;
                if (prev_wait[p] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL double_wait%0d @%0t: hreadyout low two cycles running", p, $time);
                end
            end
            prev_wait[p] = (rdy[p] !== 1'b1);
            if (hr[p] === 1'b1) begin
                if (s[p].sel && s[p].trans[1]) dp[p] = s[p].write ? DP_WRITE : DP_READ;
                else dp[p] = DP_NONE;
                if (dp[p] == DP_READ) begin
                    if (p == 0) exp_q0.push_back(rom_word(s[p].addr[ADDR_W+1:2]));
                    else exp_q1.push_back(rom_word(s[p].addr[ADDR_W+1:2]));
                end
            end
        end
        if (rst_low) begin
            dp = '{DP_NONE, DP_NONE};
            prev_wait = '{1'b0, 1'b0};
            exp_q0.delete();
            exp_q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        bus0.hsel = 1'b0; bus0.htrans = IDLE; bus0.hwrite = 1'b0; bus0.haddr = 32'h0;
        bus1.hsel = 1'b0; bus1.htrans = IDLE; bus1.hwrite = 1'b0; bus1.haddr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        cyc(idl(), idl(), 1'b0, o);
        vectors++;
        if (o !== ob(1'b0, 0, 1'b1, 1'b1)) begin
            miscompares++;
            $display("FAIL reset: got %p, expected %p", o, ob(1'b0, 0, 1'b1, 1'b1));
        end
    endtask

    task automatic test_single_read();
        stim_t a0 [2], a1 [2];
        obs_t  e [2], o;
        a0 = '{rd(32'h10), idl()};
        a1 = '{idl(), idl()};
        e  = '{ob(1, 4, 1, 1), ob(0, 0, 1, 1)};
        for (int i = 0; i < 2; i++) begin
            cyc(a0[i], a1[i], 1'b0, o);
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL single_read[%0d]: got %p, expected %p", i, o, e[i]);
            end
        end
    endtask

    task automatic test_contention();
        stim_t a0 [3], a1 [3];
        obs_t  e [3], o;
        a0 = '{rd(32'h20), idl(), idl()};
        a1 = '{rd(32'h40), idl(), idl()};
        e  = '{ob(1, 16, 1, 1), ob(1, 8, 0, 1), ob(0, 0, 1, 1)};
        for (int i = 0; i < 3; i++) begin
            cyc(a0[i], a1[i], 1'b0, o);
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL contention[%0d]: got %p, expected %p", i, o, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t a0 [5], a1 [5];
        obs_t  e [5], o;
        // Port 0 drives a stray address while stalled; the captured one must be served.
        a0 = '{rd(32'h80), rd(32'h3FC), rd(32'h140), idl(), idl()};
        a1 = '{rd(32'hC0), rd(32'h100), idl(), idl(), idl()};
        e  = '{ob(1, 48, 1, 1), ob(1, 32, 0, 1), ob(1, 64, 1, 0), ob(1, 80, 0, 1), ob(0, 0, 1, 1)};
        for (int i = 0; i < 5; i++) begin
            cyc(a0[i], a1[i], 1'b0, o);
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %p, expected %p", i, o, e[i]);
            end
        end
    endtask

    task automatic test_write();
        stim_t a0 [2], a1 [2];
        obs_t  e [2], o;
        a0 = '{rd(32'h24), idl()};
        a1 = '{wr(32'h100), idl()};
        e  = '{ob(1, 9, 1, 1), ob(0, 0, 1, 1)};
        for (int i = 0; i < 2; i++) begin
            cyc(a0[i], a1[i], 1'b0, o);
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL write[%0d]: got %p, expected %p", i, o, e[i]);
            end
        end
    endtask

    task automatic test_idle_busy();
        stim_t a0 [6], a1 [6];
        logic  st [6];
        obs_t  e [6], o;
        a0 = '{'{sel: 1'b1, trans: BUSY, write: 1'b0, addr: 32'h30}, rd(32'h30), idl(),
               '{sel: 1'b0, trans: NONSEQ, write: 1'b0, addr: 32'h50}, idl(), idl()};
        a1 = '{idl(), idl(), idl(), idl(), '{sel: 1'b1, trans: SEQ, write: 1'b0, addr: 32'h44}, idl()};
        st = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e  = '{ob(0, 0, 1, 1), ob(0, 0, 1, 1), ob(0, 0, 1, 1), ob(0, 0, 1, 1), ob(1, 17, 1, 1),
               ob(0, 0, 1, 1)};
        for (int i = 0; i < 6; i++) begin
            stall0 = st[i];
            cyc(a0[i], a1[i], 1'b0, o);
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL idle_busy[%0d]: got %p, expected %p", i, o, e[i]);
            end
        end
        stall0 = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        stim_t a0 [3], a1 [3];
        logic  rl [3];
        obs_t  e [3], o;
        a0 = '{rd(32'h20), idl(), idl()};
        a1 = '{rd(32'h40), idl(), idl()};
        rl = '{1'b0, 1'b1, 1'b0};
        e  = '{ob(1, 16, 1, 1), ob(1, 8, 0, 1), ob(0, 0, 1, 1)};
        for (int i = 0; i < 3; i++) begin
            cyc(a0[i], a1[i], rl[i], o);
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL reset_mid_stall[%0d]: got %p, expected %p", i, o, e[i]);
            end
        end
    endtask

    task automatic test_drain();
        obs_t o;
        cyc(idl(), idl(), 1'b0, o);
        vectors++;
        if (exp_q0.size() + exp_q1.size() !== 0) begin
            miscompares++;
            $display("FAIL drain: got %0d reads outstanding, expected 0",
                     exp_q0.size() + exp_q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_write();
        test_idle_busy();
        test_reset_mid_stall();
        test_single_read();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
